mac_window_accumulator: RTL and testbench

Downstream consumer of the multiply-add stage (result = a*b + c, 2*WIDTH bits, two-cycle latency). It sums a fixed window of N_SAMPLES consecutive accepted results with saturation. It then presents the window sum on a valid/ready output port and holds it until the sum is taken. It converts the per-sample multiply-add stream into dot-product-style window totals for the next stage.

---
 rtl/mac_window_accumulator.sv | 113 +++++++++++
 tb/tb_mac_window_accumulator.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mac_window_accumulator.sv
// Sums N_SAMPLES accepted multiply-add results with saturation, then holds the
// window total on a valid/ready port until downstream takes it.
module mac_window_accumulator #(
    parameter int WIDTH     = 8,
    parameter int N_SAMPLES = 4,
    parameter int ACC_WIDTH = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [2*WIDTH-1:0]   in_data,
    output logic                 in_ready,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_sat
);
    localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int EXT_W = ACC_WIDTH + 1 - 2*WIDTH;

    typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

    state_t               r_state, w_state_next;
    logic [ACC_WIDTH-1:0] r_acc, w_acc_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic                 r_sat_flag, w_sat_flag_next;
    logic                 r_out_valid, w_out_valid_next;
    logic [ACC_WIDTH-1:0] r_out_sum, w_out_sum_next;
    logic                 r_out_sat, w_out_sat_next;

    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_ovf;
    logic [ACC_WIDTH-1:0] w_sat_sum;
    logic                 w_last;

    // One extra bit of headroom: the carry out is the overflow indication.
    assign w_sum     = {1'b0, r_acc} + {{EXT_W{1'b0}}, in_data};
    assign w_ovf     = w_sum[ACC_WIDTH];
    assign w_sat_sum = w_ovf ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
    assign w_last    = (r_cnt == CNT_W'(N_SAMPLES - 1));

    assign in_ready  = reset && (r_state == ST_ACCUM);
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_sat   = r_out_sat;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat_flag  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_cnt       <= w_cnt_next;
            r_sat_flag  <= w_sat_flag_next;
            r_out_valid <= w_out_valid_next;
            r_out_sum   <= w_out_sum_next;
            r_out_sat   <= w_out_sat_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_cnt_next       = r_cnt;
        w_sat_flag_next  = r_sat_flag;
        w_out_valid_next = r_out_valid;
        w_out_sum_next   = r_out_sum;
        w_out_sat_next   = r_out_sat;

        if (clear) begin
            // Old out_sum/out_sat stay on the pins but are no longer valid.
            w_state_next     = ST_ACCUM;
            w_acc_next       = '0;
            w_cnt_next       = '0;
            w_sat_flag_next  = 1'b0;
            w_out_valid_next = 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        if (w_last) begin
                            w_out_sum_next   = w_sat_sum;
                            w_out_sat_next   = r_sat_flag | w_ovf;
                            w_out_valid_next = 1'b1;
                            w_acc_next       = '0;
                            w_cnt_next       = '0;
                            w_sat_flag_next  = 1'b0;
                            w_state_next     = ST_HOLD;
                        end else begin
                            w_acc_next      = w_sat_sum;
                            w_sat_flag_next = r_sat_flag | w_ovf;
                            w_cnt_next      = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        w_out_valid_next = 1'b0;
                        w_state_next     = ST_ACCUM;
                    end
                end
                default: w_state_next = ST_ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_window_accumulator.sv
// Randomized and directed checks of mac_window_accumulator against a
// queue-based window model (saturating sum = min(total, max)).
module tb_mac_window_accumulator;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 17;
    localparam longint MAXV = (longint'(1) << AW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [2*W-1:0] in_data = '0;
    logic          in_ready;
    logic          clear = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_sum;
    logic          out_sat;

    mac_window_accumulator #(.WIDTH(W), .N_SAMPLES(N), .ACC_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    longint win_q[$];
    bit     m_hold  = 0;
    bit     m_valid = 0;
    longint m_sum   = 0;
    bit     m_sat   = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Checks outputs against the model, advances the model with the inputs
    // currently applied, then lets the clock edge happen.
    task automatic step();
        longint total;
        @(negedge clk);
        check_val("in_ready",  longint'(in_ready),  longint'(reset && !m_hold));
        check_val("out_valid", longint'(out_valid), longint'(m_valid));
        check_val("out_sum",   longint'(out_sum),   m_sum);
        check_val("out_sat",   longint'(out_sat),   longint'(m_sat));
        if (!reset) begin
            win_q.delete();
            m_hold = 0; m_valid = 0; m_sum = 0; m_sat = 0;
        end else if (clear) begin
            win_q.delete();
            m_hold = 0; m_valid = 0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold = 0; m_valid = 0;
            end
        end else if (in_valid) begin
            win_q.push_back(longint'(in_data));
            if (win_q.size() == N) begin
                total = 0;
                foreach (win_q[i]) total += win_q[i];
                m_sum = (total > MAXV) ? MAXV : total;
                m_sat = (total > MAXV);
                m_hold = 1; m_valid = 1;
                win_q.delete();
                $display("[TB] window total=%0d expect sum=%0d sat=%0d", total, m_sum, m_sat);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int d, input bit rdy, input bit clr = 0);
        in_valid  = v;
        in_data   = (2*W)'(d);
        out_ready = rdy;
        clear     = clr;
        step();
    endtask

    initial begin
        @(posedge clk); #1;
        drive(0, 0, 1);
        drive(1, 5, 1);
        check_val("rst_sum", longint'(out_sum), 0);
        reset = 1'b1;

        // basic window
        drive(1, 10, 1); drive(1, 20, 1); drive(1, 30, 1); drive(1, 40, 1);
        check_val("t1_valid", longint'(out_valid), 1);
        check_val("t1_sum",   longint'(out_sum), 100);
        check_val("t1_ready", longint'(in_ready), 0);
        drive(0, 0, 1);
        check_val("t1_drop",  longint'(out_valid), 0);
        check_val("t1_ready2", longint'(in_ready), 1);

        // saturation, then flag not carried into next window
        repeat (4) drive(1, 65025, 1);
        check_val("sat_sum", longint'(out_sum), 131071);
        check_val("sat_flag", longint'(out_sat), 1);
        drive(0, 0, 1);
        repeat (4) drive(1, 1, 1);
        check_val("sat_next_sum", longint'(out_sum), 4);
        check_val("sat_next_flag", longint'(out_sat), 0);
        drive(0, 0, 1);

        // backpressure with in_valid held high
        drive(1, 10, 1); drive(1, 20, 1); drive(1, 30, 1); drive(1, 40, 0);
        repeat (5) drive(1, 7, 0);
        check_val("bp_valid", longint'(out_valid), 1);
        check_val("bp_sum",   longint'(out_sum), 100);
        check_val("bp_ready", longint'(in_ready), 0);
        drive(1, 7, 1);
        repeat (4) drive(1, 1, 1);
        check_val("bp_next_sum", longint'(out_sum), 4);
        drive(0, 0, 1);

        // gapped input
        drive(1, 5, 1); repeat (3) drive(0, 99, 1);
        drive(1, 5, 1); drive(1, 5, 1); drive(0, 99, 1); drive(1, 5, 1);
        check_val("gap_sum", longint'(out_sum), 20);
        check_val("gap_valid", longint'(out_valid), 1);
        drive(0, 0, 1);

        // clear mid-window and in HOLD
        drive(1, 3, 1); drive(1, 4, 1); drive(1, 50, 1, 1);
        repeat (4) drive(1, 1, 0);
        check_val("clr_sum", longint'(out_sum), 4);
        drive(1, 9, 0, 1);
        check_val("clr_hold_valid", longint'(out_valid), 0);
        check_val("clr_hold_ready", longint'(in_ready), 1);
        drive(0, 0, 1);

        // reset in HOLD and mid-window
        repeat (4) drive(1, 1, 0);
        reset = 1'b0;
        drive(0, 0, 1);
        check_val("rst_hold_valid", longint'(out_valid), 0);
        check_val("rst_hold_sum", longint'(out_sum), 0);
        reset = 1'b1;
        drive(1, 2, 1); drive(1, 2, 1);
        reset = 1'b0;
        drive(1, 2, 1);
        reset = 1'b1;
        repeat (4) drive(1, 2, 1);
        check_val("rst_fresh_sum", longint'(out_sum), 8);
        drive(0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int d;
            reset = ($urandom_range(0, 199) != 0);
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60000, 65535))
                                            : int'($urandom_range(0, 2000));
            drive(($urandom_range(0, 9) < 7), d, ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 49) == 0));
        end
        reset = 1'b1;
        drive(0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
